// File: rtl/work_transmit_pkg.sv
// Shared constants and types for the workdata frame transmitter.
//   WORK_FRAME_BYTES       bytes per workdata frame ({midstate, data2})
//   UART_DATA_BITS         data bits per UART character (8N1)
//   DEFAULT_CLOCKS_PER_BIT clk cycles per bit, shared with the serial receive/transmit blocks
package work_transmit_pkg;

  localparam int WORK_FRAME_BYTES       = 64;
  localparam int UART_DATA_BITS         = 8;
  localparam int DEFAULT_CLOCKS_PER_BIT = 434;
  localparam int FRAME_BITS             = WORK_FRAME_BYTES * UART_DATA_BITS;
  localparam int BYTE_CNT_W             = $clog2(WORK_FRAME_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_GAP
  } tx_state_t;

endpackage

// File: rtl/work_transmit_uart_tx_byte.sv
// Single-character 8N1 UART transmitter with optional idle gap after the stop bit.
//   clk        system clock
//   reset      asynchronous, active-high
//   start      load data and begin a character; honoured in IDLE or on the
//              final cycle of a character (byte_done=1), giving back-to-back output
//   data       character to send, LSB first
//   TxD        registered serial line, idle high
//   busy       a character (including gap) is in progress
//   byte_done  high on the last cycle of the stop bit / gap
//
// state    | meaning
// ---------+---------------------------------------------
// ST_IDLE  | line idle high, waiting for start
// ST_START | start bit (low), one bit-time
// ST_DATA  | data bits 0..7, one bit-time each
// ST_STOP  | stop bit (high), one bit-time
// ST_GAP   | extra idle bit-times after stop (GAP_BITS>0)
module work_transmit_uart_tx_byte
  import work_transmit_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT,
  parameter int GAP_BITS       = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [UART_DATA_BITS-1:0] data,
  output logic                      TxD,
  output logic                      busy,
  output logic                      byte_done
);

  localparam int BW = $clog2(CLOCKS_PER_BIT);
  localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLOCKS_PER_BIT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);

  tx_state_t                 state_q, state_d;
  logic [BW-1:0]             baud_q, baud_d;
  logic [2:0]                bit_q, bit_d;
  logic [GW-1:0]             gap_q, gap_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      txd_q, txd_d;
  logic                      baud_tick;

  assign baud_tick = (baud_q == BAUD_LAST);

  // Kept out of the next-state block: start depends on byte_done in the parent.
  assign byte_done = baud_tick &&
                     (((state_q == ST_STOP) && (GAP_BITS == 0)) ||
                      ((state_q == ST_GAP) && (gap_q == GAP_LAST)));

  assign TxD  = txd_q;
  assign busy = (state_q != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      data_q  <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      txd_q   <= txd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    data_d  = data_q;
    txd_d   = txd_q;

    // Baud counter free-runs through a character so bit edges never drift.
    if (state_q != ST_IDLE) begin
      baud_d = baud_tick ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_START;
          txd_d   = 1'b0;
          data_d  = data;
          baud_d  = '0;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          state_d = ST_DATA;
          bit_d   = '0;
          txd_d   = data_q[0];
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          if (bit_q == BIT_LAST) begin
            state_d = ST_STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d  = bit_q + 3'd1;
            data_d = data_q >> 1;
            txd_d  = data_q[1];
          end
        end
      end
      ST_STOP: begin
        if (baud_tick && (GAP_BITS > 0)) begin
          state_d = ST_GAP;
          gap_d   = '0;
        end
      end
      ST_GAP: begin
        if (baud_tick && (gap_q != GAP_LAST)) begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase

    if (byte_done) begin
      if (start) begin
        state_d = ST_START;
        txd_d   = 1'b0;
        data_d  = data;
      end else begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/work_transmit.sv
// Hub-side transmitter for the 512-bit workdata frame {midstate, data2}.
// Captures the frame on an accepted send and emits it as 64 UART bytes,
// most significant byte first, each byte LSB first.
//   clk       system clock
//   reset     asynchronous, active-high
//   send      request, honoured only while busy=0
//   midstate  work midstate, captured on accept
//   data2     work data2, captured on accept
//   TxD       serial line, idle high
//   busy      high from the cycle after accept until the frame ends
//   done      one-cycle pulse after the last stop bit / gap
module work_transmit
  import work_transmit_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT,
  parameter int GAP_BITS       = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         send,
  input  logic [255:0] midstate,
  input  logic [255:0] data2,
  output logic         TxD,
  output logic         busy,
  output logic         done
);

  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(WORK_FRAME_BYTES - 1);

  logic [FRAME_BITS-1:0]     frame_q;
  logic [BYTE_CNT_W-1:0]     byte_cnt_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      accept;
  logic                      byte_start;
  logic                      tx_busy;
  logic                      tx_byte_done;
  logic [UART_DATA_BITS-1:0] tx_data;

  assign accept     = send && !busy_q && !tx_busy;
  assign byte_start = accept || (tx_byte_done && (byte_cnt_q != LAST_BYTE));

  // Byte 0 comes straight off the inputs on the accept edge; later bytes are
  // the one just below the top of the register, which shifts on the same edge.
  assign tx_data = accept ? midstate[255:248]
                          : frame_q[FRAME_BITS-UART_DATA_BITS-1 -: UART_DATA_BITS];

  work_transmit_uart_tx_byte #(
    .CLOCKS_PER_BIT (CLOCKS_PER_BIT),
    .GAP_BITS       (GAP_BITS)
  ) u_tx_byte (
    .clk       (clk),
    .reset     (reset),
    .start     (byte_start),
    .data      (tx_data),
    .TxD       (TxD),
    .busy      (tx_busy),
    .byte_done (tx_byte_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_q    <= '0;
      byte_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        frame_q    <= {midstate, data2};
        byte_cnt_q <= '0;
        busy_q     <= 1'b1;
      end else if (tx_byte_done) begin
        frame_q    <= frame_q << UART_DATA_BITS;
        byte_cnt_q <= byte_cnt_q + 1'b1;
        if (byte_cnt_q == LAST_BYTE) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_work_transmit.sv
module tb_work_transmit;

  localparam int CPB   = 4;
  localparam int LEN0  = 64 * 10 * CPB;
  localparam int LEN2  = 64 * 12 * CPB;
  localparam int NLOG  = 8192;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         send = 1'b0;
  logic         sel = 1'b0;
  logic [255:0] midstate = '0;
  logic [255:0] data2 = '0;
  logic         send0, send2;
  logic         txd0, busy0, done0;
  logic         txd2, busy2, done2;
  logic         txd_s, busy_s, done_s;

  logic         txd_log  [0:NLOG-1];
  logic         busy_log [0:NLOG-1];
  logic         done_log [0:NLOG-1];
  logic [511:0] hold_frames [0:2];

  int n_cmp = 0;
  int n_err = 0;

  assign send0  = send & ~sel;
  assign send2  = send & sel;
  assign txd_s  = sel ? txd2  : txd0;
  assign busy_s = sel ? busy2 : busy0;
  assign done_s = sel ? done2 : done0;

  always #5 clk = ~clk;

  work_transmit #(.CLOCKS_PER_BIT(CPB), .GAP_BITS(0)) dut0 (
    .clk(clk), .reset(rst), .send(send0), .midstate(midstate), .data2(data2),
    .TxD(txd0), .busy(busy0), .done(done0)
  );

  work_transmit #(.CLOCKS_PER_BIT(CPB), .GAP_BITS(2)) dut2 (
    .clk(clk), .reset(rst), .send(send2), .midstate(midstate), .data2(data2),
    .TxD(txd2), .busy(busy2), .done(done2)
  );

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  // Decode 64 characters starting at log index s (first START cycle), sampling mid-bit.
  function automatic logic [511:0] decode_frame(int s, int bl);
    logic [511:0] f;
    logic [7:0]   b;
    int           base;
    f = '0;
    for (int k = 0; k < 64; k++) begin
      base = s + k * bl * CPB;
      for (int j = 0; j < 8; j++) b[j] = txd_log[base + (1 + j) * CPB + CPB / 2];
      f[511 - 8 * k -: 8] = b;
    end
    return f;
  endfunction

  // Start bits low, stop bits and every gap cycle high.
  function automatic logic framing_ok(int s, int bl);
    int base;
    for (int k = 0; k < 64; k++) begin
      base = s + k * bl * CPB;
      if (txd_log[base + CPB / 2] !== 1'b0) return 1'b0;
      if (txd_log[base + 9 * CPB + CPB / 2] !== 1'b1) return 1'b0;
      for (int c = 10 * CPB; c < bl * CPB; c++)
        if (txd_log[base + c] !== 1'b1) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int count_log(int which, int lo, int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) begin
      if (which == 0 && busy_log[i] === 1'b1) n++;
      if (which == 1 && done_log[i] === 1'b1) n++;
    end
    return n;
  endfunction

  // mode 0: pulse send; 1: pulse send and scramble inputs every cycle;
  // 2: hold send for three frames, loading hold_frames[1..2] mid-frame.
  task automatic launch_and_capture(input logic [511:0] f, input int nsamp, input int mode, input int len);
    @(negedge clk);
    {midstate, data2} = f;
    send = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= nsamp; n++) begin
      @(negedge clk);
      txd_log[n]  = txd_s;
      busy_log[n] = busy_s;
      done_log[n] = done_s;
      if (mode != 2 && n == 1) send = 1'b0;
      if (mode == 1) {midstate, data2} = {rand256(), rand256()};
      if (mode == 2) begin
        if (n == 5)             {midstate, data2} = hold_frames[1];
        if (n == (len + 1) + 5) {midstate, data2} = hold_frames[2];
        if (n == 3 * (len + 1)) send = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_cmp++; if (txd0 !== 1'b1) begin n_err++; $display("FAIL reset_txd got=%b want=1", txd0); end
    n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy0); end
    n_cmp++; if (done0 !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b want=0", done0); end
    n_cmp++; if (txd2 !== 1'b1) begin n_err++; $display("FAIL reset_txd_gap got=%b want=1", txd2); end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (txd0 !== 1'b1 || busy0 !== 1'b0) begin n_err++; $display("FAIL idle_after_reset txd=%b busy=%b want 1/0", txd0, busy0); end
  endtask

  task automatic test_basic_frame();
    logic [511:0] f;
    f = {256'h0102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F20,
         256'hA1A2A3A4A5A6A7A8A9AAABACADAEAFB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBFC0};
    sel = 1'b0;
    launch_and_capture(f, LEN0 + 4, 0, LEN0);
    n_cmp++; if (decode_frame(1, 10) !== f) begin n_err++; $display("FAIL basic_bytes got=%h want=%h", decode_frame(1, 10), f); end
    n_cmp++; if (framing_ok(1, 10) !== 1'b1) begin n_err++; $display("FAIL basic_framing got=0 want=1"); end
    n_cmp++; if (count_log(0, 1, LEN0 + 4) != LEN0) begin n_err++; $display("FAIL basic_busy_cycles got=%0d want=%0d", count_log(0, 1, LEN0 + 4), LEN0); end
    n_cmp++; if (count_log(1, 1, LEN0 + 4) != 1) begin n_err++; $display("FAIL basic_done_count got=%0d want=1", count_log(1, 1, LEN0 + 4)); end
    n_cmp++; if (done_log[LEN0 + 1] !== 1'b1 || busy_log[LEN0 + 1] !== 1'b0) begin n_err++; $display("FAIL basic_done_cycle done=%b busy=%b want 1/0", done_log[LEN0 + 1], busy_log[LEN0 + 1]); end
  endtask

  task automatic test_inputs_change();
    logic [511:0] f;
    f = {rand256(), rand256()};
    sel = 1'b0;
    launch_and_capture(f, LEN0 + 4, 1, LEN0);
    n_cmp++; if (decode_frame(1, 10) !== f) begin n_err++; $display("FAIL input_change_bytes got=%h want=%h", decode_frame(1, 10), f); end
    n_cmp++; if (count_log(1, 1, LEN0 + 4) != 1) begin n_err++; $display("FAIL input_change_done got=%0d want=1", count_log(1, 1, LEN0 + 4)); end
  endtask

  task automatic test_back_to_back();
    int nsamp;
    for (int f = 0; f < 3; f++) hold_frames[f] = {rand256(), rand256()};
    sel = 1'b0;
    nsamp = 3 * (LEN0 + 1) + 4;
    launch_and_capture(hold_frames[0], nsamp, 2, LEN0);
    for (int f = 0; f < 3; f++) begin
      n_cmp++;
      if (decode_frame(f * (LEN0 + 1) + 1, 10) !== hold_frames[f]) begin
        n_err++; $display("FAIL b2b_frame%0d got=%h want=%h", f, decode_frame(f * (LEN0 + 1) + 1, 10), hold_frames[f]);
      end
      n_cmp++;
      if (done_log[(f + 1) * (LEN0 + 1)] !== 1'b1) begin
        n_err++; $display("FAIL b2b_done_at%0d got=%b want=1", f, done_log[(f + 1) * (LEN0 + 1)]);
      end
    end
    n_cmp++; if (count_log(1, 1, nsamp) != 3) begin n_err++; $display("FAIL b2b_done_count got=%0d want=3", count_log(1, 1, nsamp)); end
    n_cmp++; if (count_log(0, 1, nsamp) != 3 * LEN0) begin n_err++; $display("FAIL b2b_busy_cycles got=%0d want=%0d", count_log(0, 1, nsamp), 3 * LEN0); end
  endtask

  task automatic test_reset_mid_frame();
    logic [511:0] f;
    int dones;
    sel = 1'b0;
    f = {rand256(), rand256()};
    // Byte 20 data bit 3 occupies cycles 1+800+16 .. 1+800+19.
    launch_and_capture(f, 818, 0, LEN0);
    rst = 1'b1;
    #1;
    n_cmp++; if (txd0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) begin n_err++; $display("FAIL midreset_outputs txd=%b busy=%b done=%b want 1/0/0", txd0, busy0, done0); end
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done0 === 1'b1 || busy0 !== 1'b0 || txd0 !== 1'b1) dones++;
    end
    rst = 1'b0;
    for (int i = 0; i < 2 * LEN0; i++) begin
      @(negedge clk);
      if (done0 === 1'b1 || busy0 !== 1'b0 || txd0 !== 1'b1) dones++;
    end
    n_cmp++; if (dones != 0) begin n_err++; $display("FAIL midreset_quiet got=%0d bad cycles want=0", dones); end
    f = {rand256(), rand256()};
    launch_and_capture(f, LEN0 + 4, 0, LEN0);
    n_cmp++; if (decode_frame(1, 10) !== f) begin n_err++; $display("FAIL midreset_resend got=%h want=%h", decode_frame(1, 10), f); end
    n_cmp++; if (done_log[LEN0 + 1] !== 1'b1 || count_log(1, 1, LEN0 + 4) != 1) begin n_err++; $display("FAIL midreset_resend_done got=%b want=1", done_log[LEN0 + 1]); end
  endtask

  task automatic test_gap_bits();
    logic [511:0] f;
    f = {rand256(), rand256()};
    sel = 1'b1;
    launch_and_capture(f, LEN2 + 4, 0, LEN2);
    n_cmp++; if (decode_frame(1, 12) !== f) begin n_err++; $display("FAIL gap_bytes got=%h want=%h", decode_frame(1, 12), f); end
    n_cmp++; if (framing_ok(1, 12) !== 1'b1) begin n_err++; $display("FAIL gap_framing got=0 want=1"); end
    n_cmp++; if (count_log(0, 1, LEN2 + 4) != LEN2) begin n_err++; $display("FAIL gap_busy_cycles got=%0d want=%0d", count_log(0, 1, LEN2 + 4), LEN2); end
    n_cmp++; if (done_log[LEN2 + 1] !== 1'b1 || count_log(1, 1, LEN2 + 4) != 1) begin n_err++; $display("FAIL gap_done got=%b want=1", done_log[LEN2 + 1]); end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_inputs_change();
    test_back_to_back();
    test_reset_mid_frame();
    test_gap_bits();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
